// File: rtl/counter_pkg.sv
// Shared types and constants for the LED-demo counter slice.
// Tick generator FSM encoding and the reset-time period.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } tick_state_e;

    // period-1 for a 100 MHz clock giving an 8 Hz tick
    localparam int unsigned DEFAULT_DIV = 12_499_999;

endpackage

// File: rtl/counter.sv
// Free-running up counter with enable, wraps at 2^BIT_WIDTH.
// Used for the LED demo and for the tick generator's tick count.
module counter #(
    parameter int unsigned BIT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    output logic [BIT_WIDTH-1:0] o_count
);

    // count up by one on each enabled cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count <= '0;
        end else if (i_en) begin
            o_count <= o_count + BIT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_tick_gen.sv
// Programmable-rate enable strobe for the LED counter.
// Periodic or one-shot ticks, runtime period load, tick count.
module counter_tick_gen #(
    parameter int unsigned DIV_WIDTH   = 24,
    parameter int unsigned DEFAULT_DIV = counter_pkg::DEFAULT_DIV,
    parameter int unsigned TCNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_run,
    input  logic                  i_oneshot,
    input  logic [DIV_WIDTH-1:0]  i_div,
    input  logic                  i_div_valid,
    output logic                  o_div_ready,
    output logic                  o_tick,
    output logic                  o_busy,
    output logic [TCNT_WIDTH-1:0] o_tick_count
);

    import counter_pkg::*;

    localparam logic [DIV_WIDTH-1:0] DIV_RST =
        DIV_WIDTH'(DEFAULT_DIV);

    tick_state_e          state_q;
    tick_state_e          state_d;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;
    logic [DIV_WIDTH-1:0] pend_q;
    logic                 pend_vld_q;
    logic                 pend_vld_d;
    logic                 tick_q;
    logic                 tick_d;
    logic                 cnt_zero;
    logic                 accept;
    logic                 xfer;

    assign cnt_zero    = (cnt_q == '0);
    assign o_div_ready = !pend_vld_q;
    assign accept      = i_div_valid && o_div_ready;
    // pending period lands at a tick reload, or at once when not counting
    assign xfer        = pend_vld_q
                       && ((state_q != COUNT) || cnt_zero);

    // state, prescaler, period and tick registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= DIV_RST;
            div_q      <= DIV_RST;
            pend_vld_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_vld_q <= pend_vld_d;
            tick_q     <= tick_d;
        end
    end

    // pending-period holding register, written only on accept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q <= '0;
        end else if (accept) begin
            pend_q <= i_div;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_run) state_d = COUNT;
            end
            COUNT: begin
                if (!i_run) begin
                    state_d = IDLE;
                end else if (cnt_zero && i_oneshot) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!i_run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // period handshake and prescaler datapath
    always_comb begin
        div_d      = div_q;
        pend_vld_d = pend_vld_q;
        if (xfer) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
        end else if (accept) begin
            pend_vld_d = 1'b1;
        end
        if (state_q == COUNT && i_run && !cnt_zero) begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
        end else begin
            cnt_d = div_d;
        end
        // registered so it is high exactly while cnt is zero
        tick_d = (state_d == COUNT) && (cnt_d == '0);
    end

    // Moore outputs
    always_comb begin
        o_busy = (state_q == COUNT);
        o_tick = tick_q;
    end

    counter #(
        .BIT_WIDTH (TCNT_WIDTH)
    ) u_tick_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (tick_q),
        .o_count (o_tick_count)
    );

endmodule

// File: tb/tb_counter_tick_gen.sv
// Directed bench for counter_tick_gen.
// DEFAULT_DIV=4, TCNT_WIDTH=2; each scenario starts from reset.
module tb_counter_tick_gen;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_run;
    logic        i_oneshot;
    logic [23:0] i_div;
    logic        i_div_valid;
    logic        o_div_ready;
    logic        o_tick;
    logic        o_busy;
    logic [1:0]  o_tick_count;

    int n_checks;
    int n_fail;

    counter_tick_gen #(
        .DIV_WIDTH   (24),
        .DEFAULT_DIV (4),
        .TCNT_WIDTH  (2)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_run        (i_run),
        .i_oneshot    (i_oneshot),
        .i_div        (i_div),
        .i_div_valid  (i_div_valid),
        .o_div_ready  (o_div_ready),
        .o_tick       (o_tick),
        .o_busy       (o_busy),
        .o_tick_count (o_tick_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n     = 1'b0;
        i_run       = 1'b0;
        i_oneshot   = 1'b0;
        i_div       = '0;
        i_div_valid = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic load_div(input logic [23:0] v);
        i_div       = v;
        i_div_valid = 1'b1;
        step();
        i_div_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        i_rst_n     = 1'b0;
        i_run       = 1'b0;
        i_oneshot   = 1'b0;
        i_div       = '0;
        i_div_valid = 1'b0;
        step();
        step();
        n_checks += 4;
        if (o_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_tick got %b exp 0", o_tick);
        end
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy got %b exp 0", o_busy);
        end
        if (o_div_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ready got %b exp 1", o_div_ready);
        end
        if (o_tick_count !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_count got %0d exp 0", o_tick_count);
        end
        i_rst_n = 1'b1;
    endtask

    task automatic test_periodic();
        logic exp_t;
        do_reset();
        i_run = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            exp_t = (c == 5 || c == 10 || c == 15);
            n_checks++;
            if (o_tick !== exp_t) begin
                n_fail++;
                $display("FAIL periodic_tick c=%0d got %b exp %b",
                         c, o_tick, exp_t);
            end
            n_checks++;
            if (o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL periodic_busy c=%0d got %b exp 1",
                         c, o_busy);
            end
        end
        n_checks++;
        if (o_tick_count !== 2'd3) begin
            n_fail++;
            $display("FAIL periodic_count got %0d exp 3", o_tick_count);
        end
        i_run = 1'b0;
    endtask

    task automatic test_oneshot();
        logic exp_t;
        do_reset();
        i_div       = 24'd2;
        i_div_valid = 1'b1;
        step();
        i_div_valid = 1'b0;
        n_checks++;
        if (o_div_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready_busy got %b exp 0", o_div_ready);
        end
        step();
        n_checks++;
        if (o_div_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready_back got %b exp 1", o_div_ready);
        end
        i_run     = 1'b1;
        i_oneshot = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            exp_t = (c == 3);
            n_checks++;
            if (o_tick !== exp_t) begin
                n_fail++;
                $display("FAIL oneshot_tick c=%0d got %b exp %b",
                         c, o_tick, exp_t);
            end
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_busy got %b exp 0", o_busy);
        end
        i_run = 1'b0;
        step();
        i_run = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            exp_t = (c == 3);
            n_checks++;
            if (o_tick !== exp_t) begin
                n_fail++;
                $display("FAIL rearm_tick c=%0d got %b exp %b",
                         c, o_tick, exp_t);
            end
        end
        n_checks++;
        if (o_tick_count !== 2'd2) begin
            n_fail++;
            $display("FAIL oneshot_count got %0d exp 2", o_tick_count);
        end
        i_run     = 1'b0;
        i_oneshot = 1'b0;
    endtask

    task automatic test_midload();
        logic exp_t;
        logic exp_r;
        do_reset();
        load_div(24'd9);
        i_run = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            step();
            exp_t = (c == 10 || c == 20 || c == 24
                  || c == 28 || c == 32);
            exp_r = !(c >= 14 && c <= 20);
            n_checks += 2;
            if (o_tick !== exp_t) begin
                n_fail++;
                $display("FAIL midload_tick c=%0d got %b exp %b",
                         c, o_tick, exp_t);
            end
            if (o_div_ready !== exp_r) begin
                n_fail++;
                $display("FAIL midload_ready c=%0d got %b exp %b",
                         c, o_div_ready, exp_r);
            end
            i_div_valid = (c == 13);
            i_div       = 24'd3;
        end
        i_run = 1'b0;
    endtask

    task automatic test_load_on_tick();
        logic exp_t;
        logic exp_r;
        do_reset();
        i_run = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            step();
            exp_t = (c == 5 || c == 10 || c == 15
                  || c == 17 || c == 19 || c == 21);
            exp_r = !(c >= 11 && c <= 15);
            n_checks += 2;
            if (o_tick !== exp_t) begin
                n_fail++;
                $display("FAIL ontick_tick c=%0d got %b exp %b",
                         c, o_tick, exp_t);
            end
            if (o_div_ready !== exp_r) begin
                n_fail++;
                $display("FAIL ontick_ready c=%0d got %b exp %b",
                         c, o_div_ready, exp_r);
            end
            i_div_valid = (c == 10);
            i_div       = 24'd1;
        end
        i_run = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_c [1:7];
        logic       exp_t;
        exp_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1};
        do_reset();
        load_div(24'd0);
        i_run = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            exp_t = (c <= 5);
            n_checks += 2;
            if (o_tick !== exp_t) begin
                n_fail++;
                $display("FAIL b2b_tick c=%0d got %b exp %b",
                         c, o_tick, exp_t);
            end
            if (o_tick_count !== exp_c[c]) begin
                n_fail++;
                $display("FAIL b2b_count c=%0d got %0d exp %0d",
                         c, o_tick_count, exp_c[c]);
            end
            if (c == 5) i_run = 1'b0;
        end
    endtask

    task automatic test_reset_midcount();
        logic exp_t;
        do_reset();
        i_run = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            i_div_valid = (c == 7);
            i_div       = 24'd2;
        end
        n_checks += 2;
        if (o_div_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_rst_ready got %b exp 0", o_div_ready);
        end
        if (o_tick_count !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_rst_count got %0d exp 1", o_tick_count);
        end
        i_rst_n = 1'b0;
        #2;
        n_checks += 3;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_busy got %b exp 0", o_busy);
        end
        if (o_div_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_ready got %b exp 1", o_div_ready);
        end
        if (o_tick_count !== 2'd0) begin
            n_fail++;
            $display("FAIL async_count got %0d exp 0", o_tick_count);
        end
        i_run = 1'b0;
        step();
        i_rst_n = 1'b1;
        i_run   = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            exp_t = (c == 5 || c == 10);
            n_checks++;
            if (o_tick !== exp_t) begin
                n_fail++;
                $display("FAIL post_rst_tick c=%0d got %b exp %b",
                         c, o_tick, exp_t);
            end
        end
        i_run = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_midload();
        test_load_on_tick();
        test_back_to_back();
        test_reset_midcount();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
